load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 32 +++
 rtl/load_store_unit.sv | 182 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the data memory (slave).
// Request side: req/we/addr/wdata/be stay stable while req is high; the slave answers with ack/rdata.
// Backpressure: the slave may delay ack indefinitely; the master holds its request until ack arrives.
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output mem_be,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  mem_be,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns EX/MEM word/halfword loads and stores into single data-memory bus accesses.
// Latency: 3 cycles request-to-DONE with a zero-wait ack, +1 per ack wait cycle; 255-cycle ack timeout.
// Backpressure: stall freezes the pipeline until DONE; optional MISALIGN_TRAP_EN traps misaligned accesses.
module load_store_unit (
  input  logic              clk,
  input  logic              reset,
  input  logic              ctrl_memRead_ex_mem,
  input  logic              ctrl_memWrite_ex_mem,
  input  logic [1:0]        ctrl_halfword_signed_ex_mem,
  input  logic [31:0]       mem_address,
  input  logic [31:0]       write_data_into_mem,
  output logic              stall,
  output logic [31:0]       read_data_from_mem,
  output logic              load_done,
  output logic              align_fault,
  output logic              bus_err,
  load_store_unit_if.master mem
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state_q, state_d;
  logic        run_q;        // low during reset and its first clock, keeps stall low while reset is held
  logic        access;
  logic        is_half;
  logic        misaligned;
  logic        start;        // access accepted this cycle (goes to REQ or traps)
  logic        timeout;
  logic [7:0]  wait_cnt_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_be_q;
  logic        is_load_q;
  logic        half_q;
  logic        signed_q;
  logic        hi_q;
  logic        ok_q;         // last access finished with an ack
  logic [15:0] lane;
  logic [31:0] load_ext;

  assign access  = ctrl_memRead_ex_mem | ctrl_memWrite_ex_mem;
  assign is_half = ctrl_halfword_signed_ex_mem[1];
  assign start   = (state_q == IDLE) && run_q && access;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = is_half ? mem_address[0] : (mem_address[1:0] != 2'b00);
`else
  // Low address bits are dropped; bit 0 has no use in this build.
  logic unused_addr_bit;
  assign unused_addr_bit = &{1'b0, mem_address[0]};
  assign misaligned      = 1'b0;
`endif

  // Halfword lane selection and sign/zero extension of the returned word.
  assign lane     = hi_q ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
  assign load_ext = half_q ? (signed_q ? {{16{lane[15]}}, lane} : {16'h0000, lane})
                           : mem.mem_rdata;

  assign mem.mem_req   = (state_q == REQ);
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_be    = mem_be_q;
  assign load_done     = (state_q == DONE) && is_load_q && ok_q;

  // Next-state, stall and timeout decode.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (run_q && access) begin
          stall   = 1'b1;
          state_d = misaligned ? DONE : REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (mem.mem_ack) begin
          state_d = DONE;
        end else if (wait_cnt_q == 8'd254) begin
          timeout = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and post-reset run flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  // Latch the bus request when an aligned access leaves IDLE; held stable through REQ.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'h0;
      half_q      <= 1'b0;
      signed_q    <= 1'b0;
      hi_q        <= 1'b0;
    end else if (start && !misaligned) begin
      mem_we_q    <= ctrl_memWrite_ex_mem;
      mem_addr_q  <= {mem_address[31:2], 2'b00};
      mem_be_q    <= is_half ? (mem_address[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      mem_wdata_q <= is_half ? (mem_address[1] ? {write_data_into_mem[15:0], 16'h0000}
                                               : {16'h0000, write_data_into_mem[15:0]})
                             : write_data_into_mem;
      half_q      <= is_half;
      signed_q    <= ctrl_halfword_signed_ex_mem[0];
      hi_q        <= mem_address[1];
    end
  end

  // Track load-vs-store and whether the access completed with an ack (gates load_done).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_load_q <= 1'b0;
      ok_q      <= 1'b0;
    end else if (start) begin
      is_load_q <= !ctrl_memWrite_ex_mem;
      ok_q      <= 1'b0;
    end else if ((state_q == REQ) && mem.mem_ack) begin
      ok_q      <= 1'b1;
    end
  end

  // Ack wait counter: cleared on entering REQ, counts REQ cycles without ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= 8'h00;
    end else if (start) begin
      wait_cnt_q <= 8'h00;
    end else if ((state_q == REQ) && !mem.mem_ack) begin
      wait_cnt_q <= wait_cnt_q + 8'd1;
    end
  end

  // Load result: updated only when a load is acked, otherwise holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data_from_mem <= 32'h0;
    end else if ((state_q == REQ) && mem.mem_ack && is_load_q) begin
      read_data_from_mem <= load_ext;
    end
  end

  // Sticky bus error on ack timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_err <= 1'b0;
    end else if (timeout) begin
      bus_err <= 1'b1;
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Sticky alignment fault when a misaligned access is trapped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      align_fault <= 1'b0;
    end else if (start && misaligned) begin
      align_fault <= 1'b1;
    end
  end
`else
  assign align_fault = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: word/halfword loads and stores, wait states,
// ack timeout, reset mid-access, and the misaligned word load in either build.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        rd, wr;
  logic [1:0]  sz;
  logic [31:0] addr, wdata;
  logic        stall, load_done, align_fault, bus_err;
  logic [31:0] read_data;

  int total = 0;
  int bad   = 0;

  logic [3:0]  seen_be;
  logic [31:0] seen_addr, seen_wdata;
  logic        seen_we;
  int          stall_n, req_n, done_n;

  load_store_unit_if mem_bus();

  load_store_unit dut (
    .clk                         (clk),
    .reset                       (reset),
    .ctrl_memRead_ex_mem         (rd),
    .ctrl_memWrite_ex_mem        (wr),
    .ctrl_halfword_signed_ex_mem (sz),
    .mem_address                 (addr),
    .write_data_into_mem         (wdata),
    .stall                       (stall),
    .read_data_from_mem          (read_data),
    .load_done                   (load_done),
    .align_fault                 (align_fault),
    .bus_err                     (bus_err),
    .mem                         (mem_bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one access from IDLE; acks after 'waits' REQ cycles (waits<0: never).
  // Ends in the first cycle with stall low (DONE), sampled mid-cycle.
  task automatic access(input logic r, input logic w, input logic [1:0] s,
                        input logic [31:0] a, input logic [31:0] d,
                        input int waits, input logic [31:0] rdat);
    rd = r; wr = w; sz = s; addr = a; wdata = d;
    mem_bus.mem_rdata = rdat;
    stall_n = 0; req_n = 0; done_n = 0;
    seen_be = 4'h0; seen_addr = 32'h0; seen_wdata = 32'h0; seen_we = 1'b0;
    for (int c = 0; c < 400; c++) begin
      #1;
      if (mem_bus.mem_req) begin
        req_n++;
        seen_be    = mem_bus.mem_be;
        seen_addr  = mem_bus.mem_addr;
        seen_wdata = mem_bus.mem_wdata;
        seen_we    = mem_bus.mem_we;
        mem_bus.mem_ack = (waits >= 0) && (req_n > waits);
      end else begin
        mem_bus.mem_ack = 1'b0;
      end
      if (stall) begin
        stall_n++;
      end else begin
        done_n = int'(load_done);
        break;
      end
      @(posedge clk);
    end
    rd = 1'b0; wr = 1'b0; mem_bus.mem_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b0; rd = 1'b0; wr = 1'b0; sz = 2'b00; addr = 32'h0; wdata = 32'h0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'h0;
    tick();
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_req", {31'h0, mem_bus.mem_req}, 32'h0);
    chk("rst_be", {28'h0, mem_bus.mem_be}, 32'h0);
    chk("rst_addr", mem_bus.mem_addr, 32'h0);
    chk("rst_rdata", read_data, 32'h0);
    chk("rst_flags", {28'h0, load_done, align_fault, bus_err, mem_bus.mem_we}, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    tick();

    // Word store, ack after 2 waits.
    access(1'b0, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF, 2, 32'h0);
    chk("sw_stall_cycles", stall_n, 4);
    chk("sw_req_cycles", req_n, 3);
    chk("sw_be", {28'h0, seen_be}, 32'hF);
    chk("sw_addr", seen_addr, 32'h10);
    chk("sw_wdata", seen_wdata, 32'hDEADBEEF);
    chk("sw_we", {31'h0, seen_we}, 32'h1);
    chk("sw_no_load_done", done_n, 0);
    chk("sw_req_low_done", {31'h0, mem_bus.mem_req}, 32'h0);
    tick();

    // Signed halfword load from upper lane.
    access(1'b1, 1'b0, 2'b11, 32'h12, 32'h0, 0, 32'h80017FFF);
    chk("lhs_stall_cycles", stall_n, 2);
    chk("lhs_be", {28'h0, seen_be}, 32'hC);
    chk("lhs_addr", seen_addr, 32'h10);
    chk("lhs_we", {31'h0, seen_we}, 32'h0);
    chk("lhs_data", read_data, 32'hFFFF8001);
    chk("lhs_load_done", done_n, 1);
    tick();
    chk("lhs_done_pulse", {31'h0, load_done}, 32'h0);
    chk("lhs_data_hold", read_data, 32'hFFFF8001);

    // Unsigned halfword load from lower lane, one wait.
    access(1'b1, 1'b0, 2'b10, 32'h10, 32'h0, 1, 32'h0000F00D);
    chk("lhu_stall_cycles", stall_n, 3);
    chk("lhu_be", {28'h0, seen_be}, 32'h3);
    chk("lhu_data", read_data, 32'h0000F00D);
    tick();

    // Signed halfword, positive value stays zero-filled.
    access(1'b1, 1'b0, 2'b11, 32'h10, 32'h0, 0, 32'h12347FFF);
    chk("lhs_pos_data", read_data, 32'h00007FFF);
    tick();

    // Halfword store to upper lane; load data must not change.
    access(1'b0, 1'b1, 2'b10, 32'h12, 32'h1234ABCD, 0, 32'h0);
    chk("sh_be", {28'h0, seen_be}, 32'hC);
    chk("sh_wdata", seen_wdata, 32'hABCD0000);
    chk("sh_data_hold", read_data, 32'h00007FFF);
    tick();

    // Word loads.
    access(1'b1, 1'b0, 2'b00, 32'h14, 32'h0, 0, 32'h12345678);
    chk("lw_addr", seen_addr, 32'h14);
    chk("lw_data", read_data, 32'h12345678);
    tick();
    access(1'b1, 1'b0, 2'b00, 32'h10, 32'h0, 0, 32'h0000F00D);
    chk("lw2_data", read_data, 32'h0000F00D);
    tick();

    // Size code 01 behaves as a word; low address bits dropped.
    access(1'b1, 1'b0, 2'b01, 32'h16, 32'h0, 0, 32'hCAFEBABE);
    chk("lw01_be", {28'h0, seen_be}, 32'hF);
    chk("lw01_addr", seen_addr, 32'h14);
    chk("lw01_data", read_data, 32'hCAFEBABE);
    tick();

    // Read and write together act as a write.
    access(1'b1, 1'b1, 2'b10, 32'h10, 32'h5555AAAA, 0, 32'h11111111);
    chk("rw_we", {31'h0, seen_we}, 32'h1);
    chk("rw_be", {28'h0, seen_be}, 32'h3);
    chk("rw_wdata", seen_wdata, 32'h0000AAAA);
    chk("rw_no_load_done", done_n, 0);
    chk("rw_data_hold", read_data, 32'hCAFEBABE);
    tick();

    // Ack while idle is ignored.
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h99999999;
    tick();
    chk("idle_ack_req", {30'h0, mem_bus.mem_req, stall}, 32'h0);
    chk("idle_ack_data", read_data, 32'hCAFEBABE);
    mem_bus.mem_ack = 1'b0;
    tick();

    // Misaligned word load.
    access(1'b1, 1'b0, 2'b00, 32'h13, 32'h0, 0, 32'hA5A5A5A5);
`ifdef MISALIGN_TRAP_EN
    chk("mis_req_cycles", req_n, 0);
    chk("mis_stall_cycles", stall_n, 1);
    chk("mis_align_fault", {31'h0, align_fault}, 32'h1);
    chk("mis_data_hold", read_data, 32'hCAFEBABE);
`else
    chk("mis_addr", seen_addr, 32'h10);
    chk("mis_align_fault", {31'h0, align_fault}, 32'h0);
    chk("mis_data", read_data, 32'hA5A5A5A5);
`endif
    tick();
    chk("pre_to_bus_err", {31'h0, bus_err}, 32'h0);

    // Load that never gets an ack.
    access(1'b1, 1'b0, 2'b00, 32'h20, 32'h0, -1, 32'h77777777);
    chk("to_req_cycles", req_n, 255);
    chk("to_stall_cycles", stall_n, 256);
    chk("to_bus_err", {31'h0, bus_err}, 32'h1);
    chk("to_req_low", {31'h0, mem_bus.mem_req}, 32'h0);
    tick();
    chk("to_released", {31'h0, stall}, 32'h0);

    // Reset in the middle of a REQ.
    rd = 1'b1; sz = 2'b00; addr = 32'h30;
    tick();
    chk("mid_req_high", {31'h0, mem_bus.mem_req}, 32'h1);
    reset = 1'b0;
    #1;
    chk("mid_rst_req", {31'h0, mem_bus.mem_req}, 32'h0);
    chk("mid_rst_stall", {31'h0, stall}, 32'h0);
    chk("mid_rst_addr", mem_bus.mem_addr, 32'h0);
    chk("mid_rst_be", {28'h0, mem_bus.mem_be}, 32'h0);
    chk("mid_rst_rdata", read_data, 32'h0);
    chk("mid_rst_flags", {28'h0, load_done, align_fault, bus_err, mem_bus.mem_we}, 32'h0);
    rd = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
